// File: rtl/transform_inverse_idct4x4_pkg.sv
// Shared widths, FSM encoding and rounding constants for the 4x4 inverse
// integer transform (row-serial, one shared butterfly).
package transform_inverse_idct4x4_pkg;

  // Datapath widths: coefficients in, row-pass results, column-pass results,
  // and the final saturated residual.
  localparam int IN_BITS  = 16;
  localparam int ROW_BITS = 18;
  localparam int COL_BITS = 20;
  localparam int OUT_BITS = 9;

  // Final normalisation: (x + RND_CONST) >>> RND_SHIFT
  localparam int RND_CONST = 32;
  localparam int RND_SHIFT = 6;

  typedef enum logic [1:0] {
    IDCT_IDLE = 2'd0,
    IDCT_ROW  = 2'd1,
    IDCT_COL  = 2'd2,
    IDCT_ZERO = 2'd3
  } idct_state_e;

endpackage

// File: rtl/transform_inverse_idct4x4_if.sv
// Block-level handshake bus: one 4x4 coefficient block in, one 4x4 residual
// block out. Arrays are raster order, index = row*4 + col.
interface transform_inverse_idct4x4_if #(
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 9
);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_BITS-1:0]  c_in  [16];
  logic                       out_valid;
  logic signed [OUT_BITS-1:0] r_out [16];

  // Producer side (drives coefficients, watches results)
  modport master (
    output in_valid,
    output c_in,
    input  in_ready,
    input  out_valid,
    input  r_out
  );

  // Transform side
  modport slave (
    input  in_valid,
    input  c_in,
    output in_ready,
    output out_valid,
    output r_out
  );

endinterface

// File: rtl/transform_inverse_idct4x4_idct4_butterfly.sv
// Combinational 4-point inverse integer butterfly. Output grows by two bits
// so that no intermediate sum can overflow.
module idct4_butterfly #(
  parameter int IN_W  = 18,
  parameter int OUT_W = IN_W + 2
) (
  input  logic signed [IN_W-1:0]  d0,
  input  logic signed [IN_W-1:0]  d1,
  input  logic signed [IN_W-1:0]  d2,
  input  logic signed [IN_W-1:0]  d3,
  output logic signed [OUT_W-1:0] o0,
  output logic signed [OUT_W-1:0] o1,
  output logic signed [OUT_W-1:0] o2,
  output logic signed [OUT_W-1:0] o3
);

  logic signed [OUT_W-1:0] x0, x1, x2, x3;
  logic signed [OUT_W-1:0] e, f, g, h;

  // Even/odd decomposition; odd taps use the half-weight arithmetic shift.
  always_comb begin
    x0 = OUT_W'(d0);
    x1 = OUT_W'(d1);
    x2 = OUT_W'(d2);
    x3 = OUT_W'(d3);
    e  = x0 + x2;
    f  = x0 - x2;
    g  = (x1 >>> 1) - x3;
    h  = x1 + (x3 >>> 1);
    o0 = e + h;
    o1 = f + g;
    o2 = f - g;
    o3 = e - h;
  end

endmodule

// File: rtl/transform_inverse_idct4x4.sv
// H.264 4x4 inverse integer transform. Four row passes into a temp buffer,
// then four column passes that round, saturate and land in the output block.
// All-zero input blocks skip the transform and clear the outputs directly.
module transform_inverse_idct4x4
  import transform_inverse_idct4x4_pkg::*;
#(
  parameter int IN_BITS  = transform_inverse_idct4x4_pkg::IN_BITS,
  parameter int OUT_BITS = transform_inverse_idct4x4_pkg::OUT_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  transform_inverse_idct4x4_if.slave    bus
);

  localparam int BF_OUT_W = ROW_BITS + 2;

  localparam logic signed [COL_BITS-1:0] SAT_HI = COL_BITS'((2 ** (OUT_BITS - 1)) - 1);
  localparam logic signed [COL_BITS-1:0] SAT_LO = COL_BITS'(-(2 ** (OUT_BITS - 1)));

  idct_state_e                 state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic signed [IN_BITS-1:0]   cin_q  [16];
  logic signed [IN_BITS-1:0]   cin_d  [16];
  logic signed [ROW_BITS-1:0]  tmp_q  [4][4];
  logic signed [ROW_BITS-1:0]  tmp_d  [4][4];
  logic signed [OUT_BITS-1:0]  rout_q [16];
  logic signed [OUT_BITS-1:0]  rout_d [16];
  logic                        out_valid_q, out_valid_d;

  logic signed [ROW_BITS-1:0]  bf_d [4];
  logic signed [BF_OUT_W-1:0]  bf_o [4];
  logic                        all_zero;

  // (x + 32) >>> 6 with one guard bit so the bias add cannot wrap
  function automatic logic signed [COL_BITS-1:0] rnd(input logic signed [COL_BITS-1:0] x);
    logic signed [COL_BITS:0] t;
    t = (COL_BITS + 1)'(x) + (COL_BITS + 1)'(RND_CONST);
    return COL_BITS'(t >>> RND_SHIFT);
  endfunction

  // Clamp to the signed residual range
  function automatic logic signed [OUT_BITS-1:0] sat(input logic signed [COL_BITS-1:0] x);
    if (x > SAT_HI)      return OUT_BITS'(SAT_HI);
    else if (x < SAT_LO) return OUT_BITS'(SAT_LO);
    else                 return OUT_BITS'(x);
  endfunction

  // Feed the shared butterfly: a sign-extended input row, or a temp column
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      if (state_q == IDCT_COL) bf_d[j] = tmp_q[j][cnt_q];
      else                     bf_d[j] = ROW_BITS'(cin_q[{cnt_q, 2'(j)}]);
    end
  end

  idct4_butterfly #(
    .IN_W  (ROW_BITS),
    .OUT_W (BF_OUT_W)
  ) u_bf (
    .d0 (bf_d[0]),
    .d1 (bf_d[1]),
    .d2 (bf_d[2]),
    .d3 (bf_d[3]),
    .o0 (bf_o[0]),
    .o1 (bf_o[1]),
    .o2 (bf_o[2]),
    .o3 (bf_o[3])
  );

  // Zero-block detect on the live input bus, used only at accept
  always_comb begin
    all_zero = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (bus.c_in[k] != '0) all_zero = 1'b0;
    end
  end

  // Next-state, buffer writes and completion pulse; everything holds when ena is low
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cin_d       = cin_q;
    tmp_d       = tmp_q;
    rout_d      = rout_q;
    out_valid_d = out_valid_q;
    if (ena) begin
      out_valid_d = 1'b0;
      unique case (state_q)
        IDCT_IDLE: begin
          if (bus.in_valid) begin
            cin_d = bus.c_in;
            cnt_d = 2'd0;
            if (all_zero) state_d = IDCT_ZERO;
            else          state_d = IDCT_ROW;
          end
        end
        IDCT_ROW: begin
          for (int j = 0; j < 4; j++) begin
            tmp_d[cnt_q][j] = bf_o[j][ROW_BITS-1:0];
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = IDCT_COL;
            cnt_d   = 2'd0;
          end
        end
        IDCT_COL: begin
          for (int i = 0; i < 4; i++) begin
            rout_d[{2'(i), cnt_q}] = sat(rnd(COL_BITS'(bf_o[i])));
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d     = IDCT_IDLE;
            cnt_d       = 2'd0;
            out_valid_d = 1'b1;
          end
        end
        IDCT_ZERO: begin
          rout_d      = '{default: '0};
          state_d     = IDCT_IDLE;
          out_valid_d = 1'b1;
        end
        default: state_d = IDCT_IDLE;
      endcase
    end
  end

  // State, counters and buffers; reset abandons any block in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDCT_IDLE;
      cnt_q       <= 2'd0;
      cin_q       <= '{default: '0};
      tmp_q       <= '{default: '{default: '0}};
      rout_q      <= '{default: '0};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cin_q       <= cin_d;
      tmp_q       <= tmp_d;
      rout_q      <= rout_d;
      out_valid_q <= out_valid_d;
    end
  end

  // A completed block is only announced while the pipeline is advancing
  assign bus.in_ready  = (state_q == IDCT_IDLE);
  assign bus.out_valid = out_valid_q & ena;
  assign bus.r_out     = rout_q;

endmodule

// File: doc/transform_inverse_idct4x4.md
Name: transform_inverse_idct4x4

Overview:
- Downstream neighbour of the inverse-quant stage. Consumes the 16 dequantised coefficients of one 4x4 block and applies the H.264 4x4 inverse integer transform.
- Implementation is row-serial: four row passes, then four column passes, through one shared 1-D butterfly.
- Applies the (x+32)>>>6 normalisation, saturates each result to 9-bit signed, and delivers the residual block to reconstruction.
- Detects an all-zero input block and returns zeros after a single cycle.

Parameters:
- IN_BITS, 16, signed width of each input coefficient.
- OUT_BITS, 9, signed width of each output residual.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global advance enable; when low, all state freezes.
- in_valid  in  1  input block present on c_in_*.
- in_ready  out  1  block can accept a new input (FSM in IDLE).
- c_in_0..c_in_15  in  IN_BITS each  signed coefficients in raster order, index = row*4+col. Sampled only on accept.
- out_valid  out  1  one-cycle pulse: r_out_* holds a new block.
- r_out_0..r_out_15  out  OUT_BITS each  signed residuals in raster order. Held until the next block completes.

Behaviour:
- Reset: FSM goes to IDLE; in_ready=1, out_valid=0, all r_out_*=0; row buffer and counters cleared. Reset asserted mid-block abandons the block and produces no out_valid.
- Accept: in the cycle where in_valid && in_ready && ena, latch all 16 coefficients into an input register. in_ready is low in every state other than IDLE.
- FSM states: IDLE, ROW, COL, ZERO.
  - IDLE -> ZERO on accept when all 16 coefficients are 0.
  - IDLE -> ROW on accept otherwise; cnt=0.
  - ROW: on each enabled cycle, butterfly row[cnt] and write 18-bit results to tmp[cnt][0..3]; cnt++. After cnt=3, go to COL with cnt=0.
  - COL: on each enabled cycle, butterfly column tmp[0..3][cnt] to 20-bit results; round and saturate into r_out rows 0..3 of column cnt; cnt++. After cnt=3, go to IDLE and pulse out_valid.
  - ZERO: on the next enabled cycle, clear r_out_* to 0, pulse out_valid, return to IDLE.
- Latency, accept to out_valid with ena held high: 9 cycles normal, 2 cycles all-zero. Each cycle with ena low extends latency by one.
- ena low: FSM, counters, buffers and outputs hold. out_valid is forced low during a stalled cycle; the pulse is issued on the completing enabled cycle.
- Back-to-back: the next accept is allowed in the same cycle out_valid pulses, since the FSM is already back in IDLE. Steady-state throughput is one block per 9 cycles.
- Butterfly, for inputs d0..d3:
  - e=d0+d2, f=d0-d2, g=(d1>>>1)-d3, h=d1+(d3>>>1)
  - o0=e+h, o1=f+g, o2=f-g, o3=e-h
  - Arithmetic right shift on signed values throughout.
- Widths: row pass has 16-bit inputs and 18-bit results. Column pass has 18-bit inputs and 20-bit results. Apply (x+32)>>>6, then saturate to [-256,255].
- r_out_* for columns not yet computed keep their previous block's values until the column is written. Consumers must sample only on out_valid.

Decomposition:
- Shared package holds:
  - width constants IN_BITS, ROW_BITS=18, COL_BITS=20, OUT_BITS;
  - FSM state encodings IDCT_IDLE, IDCT_ROW, IDCT_COL, IDCT_ZERO;
  - the rounding constant 32 and shift 6.
- One sub-module, idct4_butterfly: combinational 1-D 4-point inverse butterfly, parameterised on input width, output width = input+2. A single instance is shared by the row and column passes through input muxing.

Test Plan:
- DC only: c_in_0=64, others 0 -> out_valid 9 cycles after accept; all 16 r_out = 1.
- Single AC: c_in_1=128, others 0 -> every row of r_out = {2, 1, -1, -2}.
- All-zero block with r_out nonzero from a prior block -> out_valid 2 cycles after accept; all r_out = 0; in_ready back to 1 in the same cycle.
- Saturation: c_in_0=32767 -> all r_out = 255. Then c_in_0=-32768 -> all r_out = -256.
- Stall: DC block c_in_0=64, ena low for 3 cycles during ROW -> out_valid at 12 cycles, values unchanged (all 1); out_valid never asserted while ena=0; in_ready stays 0 throughout.
- Reset mid-block: assert rst during COL cnt=2 -> r_out all 0, no out_valid, in_ready=1 immediately. A following DC-only block (c_in_0=64) completes normally with all r_out = 1.
